// File: rtl/ib_pkg.sv
// Shared types, table sizing and the counter-step rule for the input-buffer command scheduler.
package ib_pkg;

  localparam int unsigned TOKEN_TABLE_ENTRY   = 32;
  localparam int unsigned PROGRAM_TABLE_ENTRY = 32;
  localparam int unsigned MAX_COUNTER_VALUE   = 32;
  localparam int unsigned MAX_CHANNEL_NUM     = 128;

  localparam int unsigned TID_W = $clog2(TOKEN_TABLE_ENTRY);
  localparam int unsigned PID_W = $clog2(PROGRAM_TABLE_ENTRY);
  localparam int unsigned CW    = $clog2(MAX_COUNTER_VALUE);
  localparam int unsigned CHW   = $clog2(MAX_CHANNEL_NUM);

  typedef logic [TID_W-1:0] tid_t;
  typedef logic [PID_W-1:0] pid_t;
  typedef logic [CW-1:0]    cnt_t;
  typedef logic [CHW-1:0]   chn_t;

  // Per-entry payload; valid and counters live in the counter table.
  typedef struct packed {
    pid_t dst;
    chn_t chn;
  } token_entry_t;

  typedef struct packed {
    logic [7:0] picsize;
    logic [3:0] mode;
    logic       padding;
  } prog_entry_t;

  typedef enum logic [1:0] {StIdle, StTok, StProg, StCmd} state_e;

  typedef struct packed {
    logic fire;
    cnt_t live;
  } cnt_step_t;

  // A live value of zero fires and reloads; anything else counts up towards zero.
  function automatic cnt_step_t cnt_step(cnt_t live, cnt_t reload);
    cnt_step_t s;
    s.fire = (live == '0);
    s.live = s.fire ? reload : live + cnt_t'(1);
    return s;
  endfunction

endpackage

// File: rtl/ib_cmd_scheduler_if.sv
// Packet-done event and inbuf command handshakes of the command scheduler.
interface ib_cmd_scheduler_if;
  import ib_pkg::*;

  logic        pkt_done_vld_i;
  tid_t        pkt_done_token_i;
  logic        pkt_done_rdy_o;
  logic        cmd_vld_o;
  logic        cmd_rdy_i;
  pid_t        cmd_program_o;
  logic [7:0]  cmd_pic_size_o;
  logic [3:0]  cmd_mode_o;
  logic        cmd_padding_o;
  logic        err_unconfig_o;

  modport master (
    output pkt_done_vld_i, pkt_done_token_i, cmd_rdy_i,
    input  pkt_done_rdy_o, cmd_vld_o, cmd_program_o, cmd_pic_size_o, cmd_mode_o,
           cmd_padding_o, err_unconfig_o
  );

  modport slave (
    input  pkt_done_vld_i, pkt_done_token_i, cmd_rdy_i,
    output pkt_done_rdy_o, cmd_vld_o, cmd_program_o, cmd_pic_size_o, cmd_mode_o,
           cmd_padding_o, err_unconfig_o
  );
endinterface

// File: rtl/ib_sched_counter_table.sv
// Table of period counters with payload: cfg load port, one update port, combinational fire.
module ib_sched_counter_table
  import ib_pkg::*;
#(
  parameter int unsigned Entries = 32,
  parameter int unsigned DataW   = 1,
  localparam int unsigned IdW    = $clog2(Entries)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we,
  input  logic [IdW-1:0]   cfg_id,
  input  cnt_t             cfg_load,
  input  cnt_t             cfg_reload,
  input  logic [DataW-1:0] cfg_data,
  input  logic [IdW-1:0]   id,
  input  logic             upd,
  output logic             valid,
  output logic             fire,
  output logic [DataW-1:0] data
);

  logic [Entries-1:0] valid_q;
  cnt_t               live_q   [Entries];
  cnt_t               reload_q [Entries];
  logic [DataW-1:0]   data_q   [Entries];
  cnt_step_t          step;

  assign step  = cnt_step(live_q[id], reload_q[id]);
  assign valid = valid_q[id];
  assign fire  = step.fire;
  assign data  = data_q[id];

  // The cfg write comes last so it overrides a same-cycle update of the same entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(Entries); i++) live_q[i] <= '0;
    end else begin
      if (upd && valid_q[id]) live_q[id] <= step.live;
      if (cfg_we) begin
        valid_q[cfg_id] <= 1'b1;
        live_q[cfg_id]  <= cfg_load;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (cfg_we) begin
      reload_q[cfg_id] <= cfg_reload;
      data_q[cfg_id]   <= cfg_data;
    end
  end

endmodule

// File: rtl/ib_cmd_scheduler.sv
// Input-buffer read-side scheduler: packet events step token counters, token fires step
// program counters, and program fires issue one inbuf command.
module ib_cmd_scheduler
  import ib_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cfg_token_we_i,
  input  tid_t       cfg_token_id_i,
  input  cnt_t       cfg_token_counter_i,
  input  pid_t       cfg_token_dst_i,
  input  chn_t       cfg_token_chn_i,
  input  logic       cfg_prog_we_i,
  input  pid_t       cfg_prog_id_i,
  input  cnt_t       cfg_prog_counter_i,
  input  cnt_t       cfg_prog_progress_i,
  input  logic [7:0] cfg_prog_picsize_i,
  input  logic [3:0] cfg_prog_mode_i,
  input  logic       cfg_prog_padding_i,
  ib_cmd_scheduler_if.slave bus
);

  state_e       state_q, state_d;
  tid_t         tok_q;
  pid_t         pid_q;
  pid_t         cmd_pid_q;
  prog_entry_t  cmd_q;
  token_entry_t tok_cfg, tok_rd;
  prog_entry_t  prog_cfg, prog_rd;
  logic         tok_valid, tok_fire, tok_upd;
  logic         prog_valid, prog_fire, prog_upd;
  logic         load_cmd, err;
  logic         unused_chn;

  assign tok_cfg    = '{dst: cfg_token_dst_i, chn: cfg_token_chn_i};
  assign prog_cfg   = '{picsize: cfg_prog_picsize_i, mode: cfg_prog_mode_i,
                        padding: cfg_prog_padding_i};
  assign unused_chn = ^tok_rd.chn;

  ib_sched_counter_table #(
    .Entries(TOKEN_TABLE_ENTRY),
    .DataW  ($bits(token_entry_t))
  ) u_token_table (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cfg_we    (cfg_token_we_i),
    .cfg_id    (cfg_token_id_i),
    .cfg_load  (cfg_token_counter_i),
    .cfg_reload(cfg_token_counter_i),
    .cfg_data  (tok_cfg),
    .id        (tok_q),
    .upd       (tok_upd),
    .valid     (tok_valid),
    .fire      (tok_fire),
    .data      (tok_rd)
  );

  ib_sched_counter_table #(
    .Entries(PROGRAM_TABLE_ENTRY),
    .DataW  ($bits(prog_entry_t))
  ) u_prog_table (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cfg_we    (cfg_prog_we_i),
    .cfg_id    (cfg_prog_id_i),
    .cfg_load  (cfg_prog_counter_i),
    .cfg_reload(cfg_prog_progress_i),
    .cfg_data  (prog_cfg),
    .id        (pid_q),
    .upd       (prog_upd),
    .valid     (prog_valid),
    .fire      (prog_fire),
    .data      (prog_rd)
  );

  always_comb begin
    state_d  = state_q;
    tok_upd  = 1'b0;
    prog_upd = 1'b0;
    load_cmd = 1'b0;
    err      = 1'b0;
    case (state_q)
      StIdle: if (bus.pkt_done_vld_i) state_d = StTok;
      StTok: begin
        if (!tok_valid) begin
          err     = 1'b1;
          state_d = StIdle;
        end else begin
          tok_upd = 1'b1;
          state_d = tok_fire ? StProg : StIdle;
        end
      end
      StProg: begin
        if (!prog_valid) begin
          err     = 1'b1;
          state_d = StIdle;
        end else begin
          prog_upd = 1'b1;
          load_cmd = prog_fire;
          state_d  = prog_fire ? StCmd : StIdle;
        end
      end
      StCmd: if (bus.cmd_rdy_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      tok_q     <= '0;
      pid_q     <= '0;
      cmd_pid_q <= '0;
      cmd_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.pkt_done_vld_i) tok_q <= bus.pkt_done_token_i;
      if (tok_upd && tok_fire) pid_q <= tok_rd.dst;
      if (load_cmd) begin
        cmd_pid_q <= pid_q;
        cmd_q     <= prog_rd;
      end
    end
  end

  // Handshake outputs are forced low while reset is held.
  assign bus.pkt_done_rdy_o = (state_q == StIdle) && !rst_i;
  assign bus.cmd_vld_o      = (state_q == StCmd) && !rst_i;
  assign bus.err_unconfig_o = err && !rst_i;
  assign bus.cmd_program_o  = cmd_pid_q;
  assign bus.cmd_pic_size_o = cmd_q.picsize;
  assign bus.cmd_mode_o     = cmd_q.mode;
  assign bus.cmd_padding_o  = cmd_q.padding;

endmodule

// File: tb/tb_ib_cmd_scheduler.sv
// Directed bench for ib_cmd_scheduler with an event-count reference model and per-cycle compare.
module tb_ib_cmd_scheduler;
  import ib_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_token_we = 1'b0;
  tid_t       cfg_token_id = '0;
  cnt_t       cfg_token_counter = '0;
  pid_t       cfg_token_dst = '0;
  chn_t       cfg_token_chn = '0;
  logic       cfg_prog_we = 1'b0;
  pid_t       cfg_prog_id = '0;
  cnt_t       cfg_prog_counter = '0;
  cnt_t       cfg_prog_progress = '0;
  logic [7:0] cfg_prog_picsize = '0;
  logic [3:0] cfg_prog_mode = '0;
  logic       cfg_prog_padding = 1'b0;

  ib_cmd_scheduler_if bus();

  ib_cmd_scheduler dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .cfg_token_we_i     (cfg_token_we),
    .cfg_token_id_i     (cfg_token_id),
    .cfg_token_counter_i(cfg_token_counter),
    .cfg_token_dst_i    (cfg_token_dst),
    .cfg_token_chn_i    (cfg_token_chn),
    .cfg_prog_we_i      (cfg_prog_we),
    .cfg_prog_id_i      (cfg_prog_id),
    .cfg_prog_counter_i (cfg_prog_counter),
    .cfg_prog_progress_i(cfg_prog_progress),
    .cfg_prog_picsize_i (cfg_prog_picsize),
    .cfg_prog_mode_i    (cfg_prog_mode),
    .cfg_prog_padding_i (cfg_prog_padding),
    .bus                (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dut_cmds = 0;

  // Reference model: each entry counts remaining events until it fires.
  bit          tv [32];
  int          tper [32];
  int          trem [32];
  pid_t        tdst [32];
  bit          pv [32];
  int          pper [32];
  int          prem [32];
  prog_entry_t pdat [32];
  int          ph = 0;  // 0 idle, 1 token lookup, 2 program lookup, 3 command pending
  tid_t        cur_tok;
  pid_t        cur_prog;
  pid_t        m_pid;
  prog_entry_t m_cmd;

  function automatic int period(cnt_t v);
    return ((int'(MAX_COUNTER_VALUE) - int'(v)) % int'(MAX_COUNTER_VALUE)) + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin : model
    int r;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        tv[i] <= 1'b0;
        pv[i] <= 1'b0;
      end
      ph <= 0;
    end else begin
      case (ph)
        0: if (bus.pkt_done_vld_i) begin
          cur_tok <= bus.pkt_done_token_i;
          ph      <= 1;
        end
        1: begin
          ph <= 0;
          if (tv[cur_tok]) begin
            r = trem[cur_tok] - 1;
            if (r == 0) begin
              trem[cur_tok] <= tper[cur_tok];
              cur_prog      <= tdst[cur_tok];
              ph            <= 2;
            end else trem[cur_tok] <= r;
          end
        end
        2: begin
          ph <= 0;
          if (pv[cur_prog]) begin
            r = prem[cur_prog] - 1;
            if (r == 0) begin
              prem[cur_prog] <= pper[cur_prog];
              m_pid          <= cur_prog;
              m_cmd          <= pdat[cur_prog];
              ph             <= 3;
            end else prem[cur_prog] <= r;
          end
        end
        default: if (bus.cmd_rdy_i) ph <= 0;
      endcase
      if (cfg_token_we) begin
        tv[cfg_token_id]   <= 1'b1;
        tper[cfg_token_id] <= period(cfg_token_counter);
        trem[cfg_token_id] <= period(cfg_token_counter);
        tdst[cfg_token_id] <= cfg_token_dst;
      end
      if (cfg_prog_we) begin
        pv[cfg_prog_id]   <= 1'b1;
        prem[cfg_prog_id] <= period(cfg_prog_counter);
        pper[cfg_prog_id] <= period(cfg_prog_progress);
        pdat[cfg_prog_id] <= '{picsize: cfg_prog_picsize, mode: cfg_prog_mode,
                              padding: cfg_prog_padding};
      end
    end
  end

  always @(negedge clk) begin : compare
    logic e_rdy, e_vld, e_err;
    if (rst) begin
      e_rdy = 1'b0;
      e_vld = 1'b0;
      e_err = 1'b0;
    end else begin
      e_rdy = (ph == 0);
      e_vld = (ph == 3);
      e_err = (ph == 1 && !tv[cur_tok]) || (ph == 2 && !pv[cur_prog]);
    end
    check("pkt_done_rdy", 32'(bus.pkt_done_rdy_o), 32'(e_rdy));
    check("cmd_vld", 32'(bus.cmd_vld_o), 32'(e_vld));
    check("err_unconfig", 32'(bus.err_unconfig_o), 32'(e_err));
    if (e_vld && bus.cmd_vld_o === 1'b1) begin
      check("cmd_program", 32'(bus.cmd_program_o), 32'(m_pid));
      check("cmd_pic_size", 32'(bus.cmd_pic_size_o), 32'(m_cmd.picsize));
      check("cmd_mode", 32'(bus.cmd_mode_o), 32'(m_cmd.mode));
      check("cmd_padding", 32'(bus.cmd_padding_o), 32'(m_cmd.padding));
    end
    if (bus.cmd_vld_o === 1'b1 && bus.cmd_rdy_i === 1'b1) dut_cmds <= dut_cmds + 1;
  end

  // All tasks start and end just after a falling edge.
  task automatic cfg_tok(input tid_t id, input cnt_t cnt, input pid_t dst);
    cfg_token_we = 1'b1; cfg_token_id = id; cfg_token_counter = cnt;
    cfg_token_dst = dst; cfg_token_chn = chn_t'(id) + chn_t'(1);
    @(negedge clk);
    cfg_token_we = 1'b0;
  endtask

  task automatic cfg_prog(input pid_t id, input cnt_t cnt, input cnt_t prg,
                          input logic [7:0] pic, input logic [3:0] mode, input logic pad);
    cfg_prog_we = 1'b1; cfg_prog_id = id; cfg_prog_counter = cnt; cfg_prog_progress = prg;
    cfg_prog_picsize = pic; cfg_prog_mode = mode; cfg_prog_padding = pad;
    @(negedge clk);
    cfg_prog_we = 1'b0;
  endtask

  // Holds vld until the DUT is ready; returns one falling edge after the accepting edge.
  task automatic send_event(input tid_t tok, output int acc);
    int n;
    n = 0;
    bus.pkt_done_vld_i = 1'b1;
    bus.pkt_done_token_i = tok;
    while (bus.pkt_done_rdy_o !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("accept_timeout", 32'(bus.pkt_done_rdy_o), 32'd1);
    acc = cyc;
    @(negedge clk);
    bus.pkt_done_vld_i = 1'b0;
  endtask

  initial begin : stim
    int acc, base;
    int a [4];
    bus.pkt_done_vld_i = 1'b0;
    bus.pkt_done_token_i = '0;
    bus.cmd_rdy_i = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_pkt_rdy", 32'(bus.pkt_done_rdy_o), 32'd0);
    check("rst_cmd_vld", 32'(bus.cmd_vld_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_pkt_rdy", 32'(bus.pkt_done_rdy_o), 32'd1);

    // Token 0 period 8 -> program 1 (first period 3, then 2); cfg writes land together.
    cfg_token_we = 1'b1; cfg_token_id = 5'd0; cfg_token_counter = 5'd25; cfg_token_dst = 5'd1;
    cfg_prog_we = 1'b1; cfg_prog_id = 5'd1; cfg_prog_counter = 5'd30; cfg_prog_progress = 5'd31;
    cfg_prog_picsize = 8'd8; cfg_prog_mode = 4'd2; cfg_prog_padding = 1'b1;
    @(negedge clk);
    cfg_token_we = 1'b0; cfg_prog_we = 1'b0;
    for (int i = 0; i < 23; i++) send_event(5'd0, acc);
    @(negedge clk);
    check("no_cmd_before_24", 32'(dut_cmds), 32'd0);
    send_event(5'd0, acc);
    @(negedge clk);
    check("cmd_vld_T2", 32'(bus.cmd_vld_o), 32'd0);
    @(negedge clk);
    check("cmd_vld_T3", 32'(bus.cmd_vld_o), 32'd1);
    check("cmd_prog_lit", 32'(bus.cmd_program_o), 32'd1);
    check("cmd_pic_lit", 32'(bus.cmd_pic_size_o), 32'd8);
    check("cmd_mode_lit", 32'(bus.cmd_mode_o), 32'd2);
    check("cmd_pad_lit", 32'(bus.cmd_padding_o), 32'd1);
    @(negedge clk);
    check("one_cmd_after_24", 32'(dut_cmds), 32'd1);
    for (int i = 0; i < 15; i++) send_event(5'd0, acc);
    repeat (4) @(negedge clk);
    check("still_one_cmd_39", 32'(dut_cmds), 32'd1);
    send_event(5'd0, acc);
    repeat (4) @(negedge clk);
    check("two_cmds_after_40", 32'(dut_cmds), 32'd2);

    // Backpressure: command held for 20 cycles, then a single ready pulse.
    cfg_tok(5'd2, 5'd0, 5'd4);
    cfg_prog(5'd4, 5'd0, 5'd0, 8'd3, 4'd5, 1'b0);
    bus.cmd_rdy_i = 1'b0;
    send_event(5'd2, acc);
    repeat (22) @(negedge clk);
    check("stall_vld", 32'(bus.cmd_vld_o), 32'd1);
    check("stall_pkt_rdy", 32'(bus.pkt_done_rdy_o), 32'd0);
    check("stall_pic", 32'(bus.cmd_pic_size_o), 32'd3);
    bus.cmd_rdy_i = 1'b1;
    @(negedge clk);
    bus.cmd_rdy_i = 1'b0;
    check("stall_release_vld", 32'(bus.cmd_vld_o), 32'd0);
    check("stall_cmd_count", 32'(dut_cmds), 32'd3);
    bus.cmd_rdy_i = 1'b1;

    // Unconfigured token, then a configured token pointing at an unconfigured program.
    send_event(5'd5, acc);
    check("err_tok_T1", 32'(bus.err_unconfig_o), 32'd1);
    @(negedge clk);
    check("err_tok_T2", 32'(bus.err_unconfig_o), 32'd0);
    cfg_tok(5'd3, 5'd0, 5'd9);
    send_event(5'd3, acc);
    check("err_prog_T1", 32'(bus.err_unconfig_o), 32'd0);
    @(negedge clk);
    check("err_prog_T2", 32'(bus.err_unconfig_o), 32'd1);
    @(negedge clk);
    check("err_prog_T3", 32'(bus.err_unconfig_o), 32'd0);

    // Every event fires both counters: four commands, accepts at least 4 cycles apart.
    base = dut_cmds;
    for (int i = 0; i < 4; i++) send_event(5'd2, a[i]);
    repeat (4) @(negedge clk);
    check("b2b_cmds", 32'(dut_cmds - base), 32'd4);
    for (int i = 1; i < 4; i++) check("b2b_spacing_ge4", 32'(a[i] - a[i-1] >= 4), 32'd1);

    // Reconfigure mid-count: counter restarts with the new period.
    cfg_tok(5'd0, 5'd25, 5'd1);
    cfg_prog(5'd1, 5'd0, 5'd0, 8'd8, 4'd2, 1'b1);
    base = dut_cmds;
    for (int i = 0; i < 5; i++) send_event(5'd0, acc);
    cfg_tok(5'd0, 5'd29, 5'd1);
    for (int i = 0; i < 3; i++) send_event(5'd0, acc);
    repeat (4) @(negedge clk);
    check("reconfig_no_fire", 32'(dut_cmds - base), 32'd0);
    send_event(5'd0, acc);
    repeat (4) @(negedge clk);
    check("reconfig_fire_4th", 32'(dut_cmds - base), 32'd1);

    // Cfg write in the token-update cycle: fire uses old value, cfg value is loaded.
    cfg_tok(5'd0, 5'd0, 5'd1);
    base = dut_cmds;
    bus.pkt_done_vld_i = 1'b1;
    bus.pkt_done_token_i = 5'd0;
    check("collide_ready", 32'(bus.pkt_done_rdy_o), 32'd1);
    @(negedge clk);
    bus.pkt_done_vld_i = 1'b0;
    cfg_tok(5'd0, 5'd31, 5'd1);
    repeat (3) @(negedge clk);
    check("collide_prewrite_fire", 32'(dut_cmds - base), 32'd1);
    send_event(5'd0, acc);
    repeat (4) @(negedge clk);
    check("collide_reload_nofire", 32'(dut_cmds - base), 32'd1);
    send_event(5'd0, acc);
    repeat (4) @(negedge clk);
    check("collide_reload_fire", 32'(dut_cmds - base), 32'd2);

    // Reset while a command is pending drops it and clears every entry.
    bus.cmd_rdy_i = 1'b0;
    send_event(5'd2, acc);
    repeat (2) @(negedge clk);
    check("pre_rst_vld", 32'(bus.cmd_vld_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_vld", 32'(bus.cmd_vld_o), 32'd0);
    check("mid_rst_pkt_rdy", 32'(bus.pkt_done_rdy_o), 32'd0);
    rst = 1'b0;
    bus.cmd_rdy_i = 1'b1;
    @(negedge clk);
    send_event(5'd2, acc);
    check("post_rst_err", 32'(bus.err_unconfig_o), 32'd1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
